// File: rtl/cache_defs.sv
// Shared cache constants and fill-controller state encodings.
package cache_defs;

   localparam int unsigned CACHE_ADDR_W     = 32;
   localparam int unsigned CACHE_DATA_W     = 32;
   localparam int unsigned CACHE_LINE_WORDS = 4;

   localparam logic [1:0] FILL_IDLE = 2'b00;
   localparam logic [1:0] FILL_WB   = 2'b01;
   localparam logic [1:0] FILL_FILL = 2'b10;
   localparam logic [1:0] FILL_DONE = 2'b11;

endpackage

// File: rtl/line_word_counter.sv
// Word index within a cache line; shared by the write-back and fill phases.
module line_word_counter #(
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr_i,
   input  logic                          inc_i,
   output logic [$clog2(LINE_WORDS)-1:0] cnt_o,
   output logic                          is_last_o
);

   localparam int unsigned IdxW = $clog2(LINE_WORDS);

   logic [IdxW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign is_last_o = (cnt_q == IdxW'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: optional dirty-victim write-back, then word-by-word line fetch.
// Write-back support is compiled in only when CACHE_WRITEBACK_EN is defined.
module cache_fill_ctrl
   import cache_defs::*;
#(
   parameter int unsigned ADDR_W     = CACHE_ADDR_W,
   parameter int unsigned DATA_W     = CACHE_DATA_W,
   parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          miss_req_i,
   input  logic [ADDR_W-1:0]             miss_addr_i,
   input  logic                          victim_dirty_i,
   input  logic [ADDR_W-1:0]             victim_addr_i,
   input  logic [LINE_WORDS*DATA_W-1:0]  victim_line_i,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [ADDR_W-1:0]             mem_addr_o,
   output logic [DATA_W-1:0]             mem_wdata_o,
   input  logic                          mem_ack_i,
   input  logic [DATA_W-1:0]             mem_rdata_i,
   output logic                          fill_we_o,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
   output logic [DATA_W-1:0]             fill_data_o,
   output logic                          tag_we_o,
   output logic [ADDR_W-1:0]             tag_addr_o,
   output logic                          busy_o,
   output logic                          mem_done_o
);

   localparam int unsigned IdxW = $clog2(LINE_WORDS);

   logic [1:0]             state_q, state_d;
   logic [ADDR_W-IdxW-1:0] line_hi_q;
   logic [IdxW-1:0]        cnt;
   logic                   cnt_last, cnt_clr, cnt_inc;
   logic                   accept;
   logic                   unused_bits;

   assign accept = (state_q == FILL_IDLE) && miss_req_i;

   line_word_counter #(
      .LINE_WORDS (LINE_WORDS)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .cnt_o     (cnt),
      .is_last_o (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Only the line-aligned upper bits are kept; the word index comes from the counter.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_hi_q <= miss_addr_i[ADDR_W-1:IdxW];
      end
   end

`ifdef CACHE_WRITEBACK_EN
   logic [ADDR_W-IdxW-1:0] victim_hi_q;
   logic [DATA_W-1:0]      victim_q [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (accept) begin
         victim_hi_q <= victim_addr_i[ADDR_W-1:IdxW];
         for (int i = 0; i < int'(LINE_WORDS); i++) begin
            victim_q[i] <= victim_line_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign unused_bits = ^{miss_addr_i[IdxW-1:0], victim_addr_i[IdxW-1:0]};
`else
   assign unused_bits = ^{miss_addr_i[IdxW-1:0], victim_dirty_i, victim_addr_i, victim_line_i};
`endif

   // Outputs are forced low while rst is held so an aborted fill issues nothing further.
   always_comb begin
      state_d     = state_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      fill_we_o   = 1'b0;
      fill_idx_o  = '0;
      fill_data_o = '0;
      tag_we_o    = 1'b0;
      tag_addr_o  = '0;
      mem_done_o  = 1'b0;
      if (!rst) begin
         case (state_q)
            FILL_IDLE: begin
               if (miss_req_i) begin
                  cnt_clr = 1'b1;
                  state_d = FILL_FILL;
`ifdef CACHE_WRITEBACK_EN
                  if (victim_dirty_i) begin
                     state_d = FILL_WB;
                  end
`endif
               end
            end
`ifdef CACHE_WRITEBACK_EN
            FILL_WB: begin
               mem_req_o   = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = {victim_hi_q, cnt};
               mem_wdata_o = victim_q[cnt];
               if (mem_ack_i) begin
                  if (cnt_last) begin
                     cnt_clr = 1'b1;
                     state_d = FILL_FILL;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
            end
`endif
            FILL_FILL: begin
               mem_req_o  = 1'b1;
               mem_addr_o = {line_hi_q, cnt};
               if (mem_ack_i) begin
                  fill_we_o   = 1'b1;
                  fill_idx_o  = cnt;
                  fill_data_o = mem_rdata_i;
                  if (cnt_last) begin
                     cnt_clr = 1'b1;
                     state_d = FILL_DONE;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
            end
            FILL_DONE: begin
               mem_done_o = 1'b1;
               tag_we_o   = 1'b1;
               tag_addr_o = {line_hi_q, {IdxW{1'b0}}};
               state_d    = FILL_IDLE;
            end
            default: state_d = FILL_IDLE;
         endcase
      end
   end

   assign busy_o = (state_q != FILL_IDLE) && !rst;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: random miss/stall traffic against a transfer-list model.
module tb_cache_fill_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;

   logic            clk;
   logic            rst;
   logic            miss_req;
   logic [AW-1:0]   miss_addr;
   logic            victim_dirty;
   logic [AW-1:0]   victim_addr;
   logic [LW*DW-1:0] victim_line;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_ack;
   logic [DW-1:0]   mem_rdata;
   logic            fill_we;
   logic [1:0]      fill_idx;
   logic [DW-1:0]   fill_data;
   logic            tag_we;
   logic [AW-1:0]   tag_addr;
   logic            busy;
   logic            mem_done;

   int checks = 0;
   int errors = 0;
   bit wb_en;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  idx;
   } xfer_t;

   cache_fill_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .LINE_WORDS (LW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .miss_req_i     (miss_req),
      .miss_addr_i    (miss_addr),
      .victim_dirty_i (victim_dirty),
      .victim_addr_i  (victim_addr),
      .victim_line_i  (victim_line),
      .mem_req_o      (mem_req),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_ack_i      (mem_ack),
      .mem_rdata_i    (mem_rdata),
      .fill_we_o      (fill_we),
      .fill_idx_o     (fill_idx),
      .fill_data_o    (fill_data),
      .tag_we_o       (tag_we),
      .tag_addr_o     (tag_addr),
      .busy_o         (busy),
      .mem_done_o     (mem_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at posedge+1 of the request cycle; returns at negedge of the completion cycle.
   task automatic run_txn(input logic [31:0] maddr, input bit dirty, input logic [31:0] vaddr,
                          input logic [127:0] vline, input int max_stall, input bit hold,
                          output int done_cyc);
      xfer_t       q[$];
      xfer_t       x;
      int          stall;
      bit          ack;
      bit          fin;
      logic [31:0] rd;
      for (int i = 0; i < LW; i++) begin
         if (dirty && wb_en) begin
            x.we   = 1'b1;
            x.addr = {vaddr[31:2], 2'b00} + 32'(i);
            x.data = vline[32*i +: 32];
            x.idx  = 2'(i);
            q.push_back(x);
         end
      end
      for (int i = 0; i < LW; i++) begin
         x.we   = 1'b0;
         x.addr = {maddr[31:2], 2'b00} + 32'(i);
         x.data = '0;
         x.idx  = 2'(i);
         q.push_back(x);
      end
      miss_req     = 1'b1;
      miss_addr    = maddr;
      victim_dirty = dirty;
      victim_addr  = vaddr;
      victim_line  = vline;
      mem_ack      = 1'b0;
      @(negedge clk);
      chk("idle_req", {31'd0, mem_req}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      stall    = int'($urandom_range(max_stall, 0));
      done_cyc = -1;
      fin      = 1'b0;
      for (int c = 1; c <= 200 && !fin; c++) begin
         @(posedge clk);
         #1;
         if (!hold) miss_req = 1'b0;
         miss_addr    = $urandom;
         victim_dirty = 1'($urandom);
         victim_addr  = $urandom;
         victim_line  = {$urandom, $urandom, $urandom, $urandom};
         ack          = (stall == 0);
         if (!ack) stall--;
         rd        = $urandom;
         mem_ack   = ack;
         mem_rdata = rd;
         @(negedge clk);
         if (q.size() > 0) begin
            x = q[0];
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, x.we});
            chk("mem_addr", mem_addr, x.addr);
            if (x.we) chk("mem_wdata", mem_wdata, x.data);
            chk("fill_we", {31'd0, fill_we}, {31'd0, ack && !x.we});
            if (ack && !x.we) begin
               chk("fill_idx", {30'd0, fill_idx}, {30'd0, x.idx});
               chk("fill_data", fill_data, rd);
            end
            chk("early_done", {31'd0, mem_done}, 32'd0);
            if (ack) begin
               void'(q.pop_front());
               stall = int'($urandom_range(max_stall, 0));
            end
         end else begin
            chk("mem_done", {31'd0, mem_done}, 32'd1);
            chk("tag_we", {31'd0, tag_we}, 32'd1);
            chk("tag_addr", tag_addr, {maddr[31:2], 2'b00});
            chk("done_req", {31'd0, mem_req}, 32'd0);
            chk("done_fill", {31'd0, fill_we}, 32'd0);
            chk("done_busy", {31'd0, busy}, 32'd1);
            done_cyc = c;
            fin      = 1'b1;
         end
      end
      mem_ack = 1'b0;
      if (!fin) chk("timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int dc;
`ifdef CACHE_WRITEBACK_EN
      wb_en = 1'b1;
`else
      wb_en = 1'b0;
`endif
      rst          = 1'b1;
      miss_req     = 1'b0;
      miss_addr    = '0;
      victim_dirty = 1'b0;
      victim_addr  = '0;
      victim_line  = '0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, mem_done}, 32'd0);
      chk("rst_fill", {31'd0, fill_we}, 32'd0);
      chk("rst_tag", {31'd0, tag_we}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Clean miss, ack every cycle.
      run_txn(32'h0000_1236, 1'b0, 32'h0, 128'h0, 0, 1'b0, dc);
      chk("lat_clean", 32'(dc), 32'd5);
      @(posedge clk);
      #1;

      // Dirty victim; write-through builds must skip the writes.
      run_txn(32'h0000_2005, 1'b1, 32'h0000_0800,
              {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 0, 1'b0, dc);
      chk("lat_dirty", 32'(dc), wb_en ? 32'd9 : 32'd5);
      @(posedge clk);
      #1;

      // Random traffic with 0..3 cycle ack stalls.
      repeat (8) begin
         run_txn($urandom, 1'($urandom), $urandom,
                 {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, dc);
         @(posedge clk);
         #1;
      end

      // miss_req held high throughout: one sequence each, next accepted in first IDLE cycle.
      run_txn(32'h0000_3330, 1'b0, 32'h0, 128'h0, 1, 1'b1, dc);
      @(posedge clk);
      #1;
      run_txn(32'h0000_5557, 1'b1, 32'h0000_6660,
              {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, dc);
      chk("lat_hold", 32'(dc), wb_en ? 32'd9 : 32'd5);
      @(posedge clk);
      #1;
      miss_req = 1'b0;
      @(negedge clk);
      chk("post_hold_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("no_extra_busy", {31'd0, busy}, 32'd0);

      // Reset after the second fill ack.
      @(posedge clk);
      #1;
      miss_req     = 1'b1;
      miss_addr    = 32'h0000_4440;
      victim_dirty = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         miss_req  = 1'b0;
         mem_ack   = 1'b1;
         mem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_fill", {31'd0, fill_we}, 32'd0);
      chk("rstmid_done", {31'd0, mem_done}, 32'd0);
      chk("rstmid_tag", {31'd0, tag_we}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_req", {31'd0, mem_req}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      repeat (6) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("rst_no_done", {31'd0, mem_done}, 32'd0);
         chk("rst_no_tag", {31'd0, tag_we}, 32'd0);
         chk("rst_no_fill", {31'd0, fill_we}, 32'd0);
      end
      mem_ack = 1'b0;
      @(posedge clk);
      #1;

      // Recovery after reset.
      run_txn($urandom, 1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, dc);
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
